// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S frame constants, field positions and receiver FSM encoding.
package i2s_pkg;
  localparam int DEF_SAMPLE_BITS = 16;
  localparam int DEF_SLOT_BITS = 32;
  localparam int LEFT_MSB = 31;
  localparam int RIGHT_MSB = 15;
  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_e;
endpackage

// File: rtl/i2s_edge_sync.sv
// i2s_edge_sync: 2-FF synchronisers for bck/lrck/sin plus a BCK rising-edge strobe.
module i2s_edge_sync (
  input  logic in_clk,
  input  logic reset,
  input  logic bck_i,
  input  logic lrck_i,
  input  logic sin_i,
  output logic lr_o,
  output logic sin_o,
  output logic brise_o
);
  logic [2:0] bck_q;
  logic [1:0] lr_q, sin_q;
  always_ff @(posedge in_clk) begin
    if (reset) begin
      bck_q <= '0;
      lr_q  <= '0;
      sin_q <= '0;
    end else begin
      bck_q <= {bck_q[1:0], bck_i};
      lr_q  <= {lr_q[0], lrck_i};
      sin_q <= {sin_q[0], sin_i};
    end
  end
  assign lr_o    = lr_q[1];
  assign sin_o   = sin_q[1];
  assign brise_o = bck_q[1] & ~bck_q[2];
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampled 64fs I2S receiver producing {left, right} words with lock tracking.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int TIMEOUT     = 255
) (
  input  logic              in_clk,
  input  logic              reset,
  input  logic              bck,
  input  logic              lrck,
  input  logic              sin,
  output logic [LEFT_MSB:0] out_data,
  output logic              out_valid,
  output logic              locked,
  output logic              frame_err
);
  localparam int IW = $clog2(TIMEOUT + 1);
  logic lr_s, sin_s, brise;
  state_e state_q, state_d;
  logic lr_prev_q, out_valid_q, locked_q, frame_err_q;
  logic [5:0] bit_cnt_q;
  logic [SAMPLE_BITS-1:0] left_q, right_q;
  logic [IW-1:0] idle_q;
  logic [LEFT_MSB:0] out_data_q;
  logic bound, len_ok, timeout, capture, publish, err;
  i2s_edge_sync u_sync (
    .in_clk (in_clk),
    .reset  (reset),
    .bck_i  (bck),
    .lrck_i (lrck),
    .sin_i  (sin),
    .lr_o   (lr_s),
    .sin_o  (sin_s),
    .brise_o(brise)
  );
  assign bound   = brise && (lr_s != lr_prev_q);
  assign len_ok  = bit_cnt_q == 6'(SLOT_BITS);
  assign timeout = !brise && idle_q == IW'(TIMEOUT);
  // I2S one-bit delay: the brise after a boundary (bit_cnt 1) carries the MSB
  assign capture = brise && !bound && bit_cnt_q != '0 && bit_cnt_q <= 6'(SAMPLE_BITS);
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    err     = 1'b0;
    if (timeout) state_d = UNLOCKED;
    else if (bound && state_q == UNLOCKED) state_d = lr_s ? UNLOCKED : LEFT;
    else if (bound) begin
      err     = !len_ok;
      publish = len_ok && !lr_s && state_q == RIGHT;
      state_d = lr_s ? (len_ok ? RIGHT : UNLOCKED) : LEFT;
    end
  end
  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      lr_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      left_q      <= '0;
      right_q     <= '0;
      idle_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (brise) begin
        lr_prev_q <= lr_s;
        bit_cnt_q <= bound ? 6'd1 : (bit_cnt_q == 6'd63 ? bit_cnt_q : bit_cnt_q + 6'd1);
      end
      if (capture && lr_s) right_q <= {right_q[SAMPLE_BITS-2:0], sin_s};
      if (capture && !lr_s) left_q <= {left_q[SAMPLE_BITS-2:0], sin_s};
      idle_q      <= brise ? '0 : (idle_q == IW'(TIMEOUT) ? idle_q : idle_q + IW'(1));
      out_valid_q <= publish;
      frame_err_q <= err;
      if (publish) out_data_q <= {left_q, right_q};
      locked_q <= publish ? 1'b1 : ((err || timeout) ? 1'b0 : locked_q);
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed frame vectors plus timeout and mid-frame reset sequences.
module tb_i2s_receiver;
  localparam int H = 4;
  logic in_clk = 0, reset = 1, bck = 0, lrck = 1, sin = 0;
  logic [31:0] out_data;
  logic out_valid, locked, frame_err;
  int nvec = 0, nerr = 0, vcnt = 0, ecnt = 0;
  typedef struct {
    logic [31:0] word;
    int lbits;
    int exp_v;
    int exp_e;
    logic [31:0] exp_data;
    logic exp_lock;
  } vec_t;
  vec_t tbl [9];
  i2s_receiver dut (
    .in_clk   (in_clk),
    .reset    (reset),
    .bck      (bck),
    .lrck     (lrck),
    .sin      (sin),
    .out_data (out_data),
    .out_valid(out_valid),
    .locked   (locked),
    .frame_err(frame_err)
  );
  always #10 in_clk = ~in_clk;
  always @(negedge in_clk) begin
    if (out_valid) vcnt++;
    if (frame_err) ecnt++;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_period(input logic lr, input logic s);
    bck = 0;
    lrck = lr;
    sin = s;
    repeat (H) @(negedge in_clk);
    bck = 1;
    repeat (H) @(negedge in_clk);
  endtask
  task automatic send_slot(input logic lr, input logic [15:0] d, input int first, input int last);
    for (int k = first; k < last; k++) send_period(lr, (k >= 1 && k <= 16) ? d[16-k] : 1'b0);
  endtask
  task automatic send_frame(input logic [31:0] w, input int lbits);
    send_slot(1'b0, w[31:16], 0, lbits);
    send_slot(1'b1, w[15:0], 0, 32);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int v0, e0;
    tbl[0] = '{32'hD9999991, 32, 0, 0, 32'h00000000, 1'b0};
    tbl[1] = '{32'hD9999991, 32, 0, 0, 32'h00000000, 1'b0};
    tbl[2] = '{32'hD9999991, 32, 1, 0, 32'hD9999991, 1'b1};
    tbl[3] = '{32'h99999993, 32, 1, 0, 32'hD9999991, 1'b1};
    tbl[4] = '{32'h99999983, 32, 1, 0, 32'h99999993, 1'b1};
    tbl[5] = '{32'h12345678, 31, 1, 1, 32'h99999983, 1'b0};
    tbl[6] = '{32'hABCD1234, 32, 0, 0, 32'h99999983, 1'b0};
    tbl[7] = '{32'h00000000, 32, 1, 0, 32'hABCD1234, 1'b1};
    tbl[8] = '{32'h5A5AA5A5, 32, 1, 0, 32'h00000000, 1'b1};
    repeat (3) @(negedge in_clk);
    check("rst_data", out_data, 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(frame_err), 0);
    reset = 0;
    repeat (2) @(negedge in_clk);
    for (int i = 0; i < 9; i++) begin
      v0 = vcnt;
      e0 = ecnt;
      send_frame(tbl[i].word, tbl[i].lbits);
      check($sformatf("v%0d_valid_cnt", i), 32'(vcnt - v0), 32'(tbl[i].exp_v));
      check($sformatf("v%0d_err_cnt", i), 32'(ecnt - e0), 32'(tbl[i].exp_e));
      check($sformatf("v%0d_data", i), out_data, tbl[i].exp_data);
      check($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].exp_lock));
    end
    e0 = ecnt;
    repeat (200) @(negedge in_clk);
    check("idle_200_locked", 32'(locked), 1);
    repeat (100) @(negedge in_clk);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_err_cnt", 32'(ecnt - e0), 0);
    v0 = vcnt;
    send_frame(32'hC3C33C3C, 32);
    check("restart_first_valid_cnt", 32'(vcnt - v0), 0);
    v0 = vcnt;
    send_frame(32'h0F0FF0F0, 32);
    check("restart_second_valid_cnt", 32'(vcnt - v0), 1);
    check("restart_data", out_data, 32'hC3C33C3C);
    check("restart_locked", 32'(locked), 1);
    send_slot(1'b0, 16'h1111, 0, 32);
    send_slot(1'b1, 16'h2222, 0, 10);
    reset = 1;
    repeat (2) @(negedge in_clk);
    check("midrst_data", out_data, 0);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_err", 32'(frame_err), 0);
    reset = 0;
    v0 = vcnt;
    e0 = ecnt;
    send_slot(1'b1, 16'h2222, 10, 32);
    send_frame(32'h77778888, 32);
    check("midrst_no_valid", 32'(vcnt - v0), 0);
    check("midrst_locked_after", 32'(locked), 0);
    v0 = vcnt;
    send_frame(32'h44443333, 32);
    check("midrst_valid_cnt", 32'(vcnt - v0), 1);
    check("midrst_new_data", out_data, 32'h77778888);
    check("midrst_relocked", 32'(locked), 1);
    check("midrst_err_cnt", 32'(ecnt - e0), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
